digit_sequencer: RTL and testbench
==================================

DIGIT_SEQUENCER -- requirements
Module: digit_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops on io_in[7:2].
REQ-002 SHALL have parameter PRE_W, default 12, prescaler counter width; divisors are 1, 16, 256 and 4096.
REQ-003 SHALL have port io_in[0], input, 1 bit: clk; the only clock, rising edge.
REQ-004 SHALL have port io_in[1], input, 1 bit: rst_n; asynchronous, active-low reset.
REQ-005 SHALL have port io_in[2], input, 1 bit: run; level, 1 = count.
REQ-006 SHALL have port io_in[3], input, 1 bit: dir; 1 = up, 0 = down.
REQ-007 SHALL have port io_in[4], input, 1 bit: clr; its rising edge is a synchronous clear.
REQ-008 SHALL have port io_in[5], input, 1 bit: hex; 1 = range 0..15, 0 = BCD range 0..9.
REQ-009 SHALL have port io_in[7:6], input, 2 bits: psel; selects the divisor, 0→1, 1→16, 2→256, 3→4096.
REQ-010 SHALL have port io_out[3:0], output, 4 bits: digit; the 4-bit code driven into the downstream 7-segment decoder.
REQ-011 SHALL have port io_out[4], output, 1 bit: tc; one-cycle terminal-count pulse.
REQ-012 SHALL have port io_out[5], output, 1 bit: busy; high while the FSM is in RUN.
REQ-013 SHALL have port io_out[6], output, 1 bit: tick; one-cycle pulse on every digit step.
REQ-014 SHALL have port io_out[7], output, 1 bit: ovf; sticky flag, set by any tc.

Function
REQ-015 SHALL pass io_in[7:2] through SYNC_STAGES flops, so any input change acts SYNC_STAGES+1 edges later; only synchronized copies are used.
REQ-016 SHALL detect a clr rising edge as: synchronized clr = 1 and its previous value = 0.
REQ-017 SHALL implement an FSM with states IDLE and RUN: IDLE→RUN when run=1; RUN→IDLE when run=0; a clr edge does not change state.
REQ-018 SHALL zero the prescaler on entry to RUN, on a clr edge, and on any change of synchronized psel.
REQ-019 SHALL, in RUN, increment the prescaler each cycle and assert the internal step when prescaler = divisor-1, then wrap it to 0.
REQ-020 SHALL, with divisor 1, step on every RUN cycle, starting on the first cycle after entering RUN.
REQ-021 SHALL, on a step with dir=1, set digit to digit+1, or to 0 with tc=1 when digit = max (9 BCD, 15 hex).
REQ-022 SHALL, on a step with dir=0, set digit to digit-1, or to max with tc=1 when digit = 0.
REQ-023 SHALL, in BCD mode with digit > 9 after a hex→BCD switch, have the next step load 0 (up) or 9 (down), with tc=0.
REQ-024 SHALL register digit, tc and tick together on the same edge; tick=1 for exactly that cycle, tc=1 only on wrap cycles.
REQ-025 SHALL give a clr edge priority over a coincident step: digit=0, prescaler=0, ovf=0, tc=0, tick=0 in that cycle.
REQ-026 SHALL set ovf on any tc and hold it until a clr edge or reset; a tc coincident with clr cannot occur, by REQ-025.
REQ-027 SHALL, in IDLE, hold digit and prescaler frozen and keep tc=tick=0; a dir or hex change in IDLE has no effect until the next step.
REQ-028 SHALL register busy; it equals 1 in RUN and 0 in IDLE.
REQ-029 SHALL drive all outputs from flops with no combinational path from io_in to io_out.

Reset
REQ-030 SHALL, while rst_n=0, immediately and asynchronously force: FSM=IDLE, digit=0, prescaler=0, tc=0, tick=0, busy=0, ovf=0, synchronizer flops=0.
REQ-031 SHALL, when reset asserts mid-count, discard the count in progress; after release, counting resumes only via REQ-015/017.
REQ-032 SHALL release reset synchronously to clk, so the first active edge after rst_n rises behaves as a normal edge.

Verification
REQ-033 Reset then run=1, dir=1, hex=0, psel=0 → digit steps 0,1,…,9,0 on consecutive cycles; tc=1 only on the 9→0 cycle; ovf=1 afterwards.
REQ-034 run=1, dir=0, hex=1, psel=1 from digit 0 → the first step gives digit 15 with tc=1, and tick pulses are exactly 16 cycles apart.
REQ-035 At digit 12 with hex=1, drop hex to 0, dir=1 → the next step gives digit 0 with tc=0; repeat with dir=0 → digit 9 with tc=0.
REQ-036 psel=0 with a clr rising edge landing on a step cycle → digit=0, tc=0, tick=0, ovf cleared; counting continues next cycle.
REQ-037 Assert rst_n=0 mid-count at digit 7, psel=2 → all outputs are 0 before the next clk edge; after release with run=1, the first tick occurs after 256 RUN cycles.
REQ-038 Toggle run 1→0 at digit 4 → busy falls, digit holds 4 indefinitely, and no tick occurs; restoring run resumes from 4 with a full divisor period.

Source files
------------

// File: rtl/digit_sequencer.sv
// Single-digit up/down counter (BCD or hex) stepped by a power-of-16 prescaler, with
// synchronized control inputs, sticky overflow and all outputs registered.
module digit_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PRE_W       = 12
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic {StIdle, StRun} state_e;

  logic clk;
  logic rst_n;
  assign clk   = io_in[0];
  assign rst_n = io_in[1];

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
  logic                        clr_prev_q, clr_prev_d;
  logic [1:0]                  psel_prev_q, psel_prev_d;
  logic [PRE_W-1:0]            pre_q, pre_d;
  logic [3:0]                  digit_q, digit_d;
  logic                        tc_q, tc_d;
  logic                        tick_q, tick_d;
  logic                        busy_q, busy_d;
  logic                        ovf_q, ovf_d;

  logic [5:0]       in_s;
  logic             run_s, dir_s, clr_s, hex_s;
  logic [1:0]       psel_s;
  logic             clr_edge, psel_chg, step;
  logic [PRE_W-1:0] div_m1;
  logic [3:0]       digit_max;

  assign in_s     = sync_q[SYNC_STAGES-1];
  assign run_s    = in_s[0];
  assign dir_s    = in_s[1];
  assign clr_s    = in_s[2];
  assign hex_s    = in_s[3];
  assign psel_s   = in_s[5:4];
  assign clr_edge = clr_s & ~clr_prev_q;
  assign psel_chg = (psel_s != psel_prev_q);

  always_comb begin
    sync_d[0] = io_in[7:2];
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    clr_prev_d  = clr_s;
    psel_prev_d = psel_s;
  end

  always_comb begin
    case (psel_s)
      2'd0:    div_m1 = '0;
      2'd1:    div_m1 = PRE_W'(15);
      2'd2:    div_m1 = PRE_W'(255);
      default: div_m1 = PRE_W'(4095);
    endcase
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run_s) state_d = StRun;
      StRun:   if (!run_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_d = (state_d == StRun);
  end

  always_comb begin
    pre_d     = pre_q;
    digit_d   = digit_q;
    tc_d      = 1'b0;
    tick_d    = 1'b0;
    ovf_d     = ovf_q;
    step      = 1'b0;
    digit_max = hex_s ? 4'd15 : 4'd9;

    if (state_q == StRun) begin
      step  = (pre_q == div_m1);
      pre_d = step ? '0 : pre_q + 1'b1;
    end
    if (state_q == StIdle && state_d == StRun) pre_d = '0;
    // A divisor change restarts the period instead of stepping with a stale count.
    if (psel_chg) begin
      pre_d = '0;
      step  = 1'b0;
    end

    if (clr_edge) begin
      pre_d   = '0;
      digit_d = '0;
      ovf_d   = 1'b0;
    end else if (step) begin
      tick_d = 1'b1;
      if (dir_s) begin
        if (digit_q > digit_max) begin
          digit_d = '0;
        end else if (digit_q == digit_max) begin
          digit_d = '0;
          tc_d    = 1'b1;
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end else begin
        // Out-of-range digit after a hex->BCD switch reloads without a terminal count.
        if (digit_q > digit_max) begin
          digit_d = digit_max;
        end else if (digit_q == 4'd0) begin
          digit_d = digit_max;
          tc_d    = 1'b1;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end
      ovf_d = ovf_q | tc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sync_q      <= '0;
      clr_prev_q  <= 1'b0;
      psel_prev_q <= 2'd0;
      pre_q       <= '0;
      digit_q     <= 4'd0;
      tc_q        <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      clr_prev_q  <= clr_prev_d;
      psel_prev_q <= psel_prev_d;
      pre_q       <= pre_d;
      digit_q     <= digit_d;
      tc_q        <= tc_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign io_out = {ovf_q, tick_q, busy_q, tc_q, digit_q};

endmodule

// File: tb/tb_digit_sequencer.sv
// Bench for digit_sequencer: directed scenarios plus random control traffic, every cycle
// compared against a cycle-level reference model of the counting rules.
module tb_digit_sequencer;

  localparam int unsigned SS = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       run   = 1'b0;
  logic       dir   = 1'b0;
  logic       clr   = 1'b0;
  logic       hex   = 1'b0;
  logic [1:0] psel  = 2'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {psel, hex, clr, dir, run, rst_n, clk};

  digit_sequencer #(.SYNC_STAGES(SS), .PRE_W(12)) dut (.io_in(io_in), .io_out(io_out));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [5:0]  m_hist [SS];
  logic [5:0]  m_prev;
  bit          m_running;
  int unsigned m_pre;
  int          m_digit;
  bit          m_tc, m_tick, m_ovf;

  function automatic void m_reset();
    for (int i = 0; i < int'(SS); i++) m_hist[i] = '0;
    m_prev    = '0;
    m_running = 0;
    m_pre     = 0;
    m_digit   = 0;
    m_tc      = 0;
    m_tick    = 0;
    m_ovf     = 0;
  endfunction

  function automatic logic [7:0] m_out();
    return {m_ovf, m_tick, m_running, m_tc, 4'(m_digit)};
  endfunction

  // One clock edge: s holds the control inputs as they were SS edges ago.
  function automatic void m_edge();
    logic [5:0]  s        = m_hist[SS-1];
    bit          clr_edge = s[2] && !m_prev[2];
    bit          pschg    = (s[5:4] != m_prev[5:4]);
    int unsigned div      = 1 << (4 * int'(s[5:4]));
    int          dmax     = s[3] ? 15 : 9;
    bit          step     = 0;
    if (m_running) begin
      if (m_pre == div - 1) begin
        step  = 1;
        m_pre = 0;
      end else begin
        m_pre++;
      end
    end else if (s[0]) begin
      m_pre = 0;
    end
    if (pschg) begin
      m_pre = 0;
      step  = 0;
    end
    m_tc   = 0;
    m_tick = 0;
    if (clr_edge) begin
      m_pre   = 0;
      m_digit = 0;
      m_ovf   = 0;
    end else if (step) begin
      m_tick = 1;
      if (s[1]) begin
        if (m_digit > dmax) m_digit = 0;
        else if (m_digit == dmax) begin m_digit = 0; m_tc = 1; end
        else m_digit++;
      end else begin
        if (m_digit > dmax) m_digit = dmax;
        else if (m_digit == 0) begin m_digit = dmax; m_tc = 1; end
        else m_digit--;
      end
      if (m_tc) m_ovf = 1;
    end
    m_running = s[0];
    m_prev    = s;
    for (int i = int'(SS) - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = io_in[7:2];
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst_n) m_edge();
      @(negedge clk);
      chk("model", io_out, m_out());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {run, dir, clr, hex, psel} = '0;
    m_reset();
    #1 chk("reset_async", io_out, 8'h00);
    cycles(2);
  endtask

  task automatic release_rst(input logic r, input logic d, input logic h, input logic [1:0] p);
    run   = r;
    dir   = d;
    hex   = h;
    psel  = p;
    clr   = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);

    // BCD up count on every cycle, wrap 9->0 with tc and sticky ovf
    do_reset();
    release_rst(1'b1, 1'b1, 1'b0, 2'd0);
    cycles(12);
    chk("bcd_nine", io_out, 8'h69);
    cycles(1);
    chk("bcd_wrap", io_out, 8'hF0);
    cycles(1);
    chk("bcd_after_wrap", io_out, 8'hE1);

    // Hex down count with divisor 16, then hex->BCD switch at digit 12
    do_reset();
    release_rst(1'b1, 1'b0, 1'b1, 2'd1);
    cycles(18);
    chk("hex_pre_first", io_out, 8'h20);
    cycles(1);
    chk("hex_first_wrap", io_out, 8'hFF);
    cycles(15);
    chk("hex_gap_quiet", io_out, 8'hAF);
    cycles(1);
    chk("hex_gap_16", io_out, 8'hEE);
    cycles(32);
    chk("hex_at_12", io_out, 8'hEC);
    hex = 1'b0;
    dir = 1'b1;
    cycles(16);
    chk("bcd_oor_up", io_out, 8'hE0);
    hex = 1'b1;
    cycles(192);
    chk("hex_at_12_again", io_out, 8'hEC);
    hex = 1'b0;
    dir = 1'b0;
    cycles(16);
    chk("bcd_oor_down", io_out, 8'hE9);

    // Clear edge landing on a step cycle
    do_reset();
    release_rst(1'b1, 1'b1, 1'b0, 2'd0);
    cycles(16);
    chk("clr_before", io_out, 8'hE3);
    clr = 1'b1;
    cycles(3);
    chk("clr_wins", io_out, 8'h20);
    cycles(1);
    chk("clr_resume", io_out, 8'h61);
    clr = 1'b0;
    cycles(4);

    // Pause at digit 4 and resume with a full divisor period
    do_reset();
    release_rst(1'b1, 1'b1, 1'b0, 2'd1);
    cycles(67);
    chk("pause_at4", io_out, 8'h64);
    run = 1'b0;
    cycles(3);
    chk("pause_busy_low", io_out, 8'h04);
    cycles(200);
    chk("pause_hold", io_out, 8'h04);
    run = 1'b1;
    cycles(18);
    chk("resume_wait", io_out, 8'h24);
    cycles(1);
    chk("resume_step", io_out, 8'h65);

    // Reset mid-count, psel=2
    do_reset();
    release_rst(1'b1, 1'b1, 1'b0, 2'd2);
    cycles(1845);
    chk("slow_at7", io_out, 8'h27);
    #2 rst_n = 1'b0;
    m_reset();
    #1 chk("midcount_reset", io_out, 8'h00);
    @(negedge clk);
    cycles(2);
    rst_n = 1'b1;
    cycles(258);
    chk("slow_first_wait", io_out, 8'h20);
    cycles(1);
    chk("slow_first_tick", io_out, 8'h61);

    // Random control traffic
    for (int k = 0; k < 200; k++) begin
      run  = ($urandom_range(0, 9) != 0);
      dir  = 1'($urandom);
      hex  = 1'($urandom);
      clr  = ($urandom_range(0, 5) == 0);
      psel = 2'($urandom_range(0, 1));
      cycles(int'($urandom_range(1, 30)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
